// File: rtl/pll_scan_ctrl_pkg.sv
// Shared types and constants for the video PLL scan-chain controller.
// Cyclone III scan-chain length and controller state encodings.
package pll_scan_ctrl_pkg;

  localparam int PLL_SCAN_LEN = 144;
  localparam int DRAIN_CYCLES = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WAIT_RECONF,
    S_UPDATE,
    S_WAIT_DONE
  } state_t;

endpackage

// File: rtl/pll_scan_timeout.sv
// Wait-state timer: counts while enabled, flags when LIMIT is reached.
// Cleared whenever its owning wait state is not active.
module pll_scan_timeout #(
  parameter int LIMIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign expired = enable && (count == W'(LIMIT));

endmodule

// File: rtl/pll_scan_ctrl.sv
// Scan-chain controller: shifts ROM bits into the PLL scan chain,
// then sequences configupdate and waits for scandone.
module pll_scan_ctrl
  import pll_scan_ctrl_pkg::*;
#(
  parameter int SCAN_LEN       = PLL_SCAN_LEN,
  parameter int ADDR_W         = 8,
  parameter int RECONF_TIMEOUT = 15,
  parameter int DONE_TIMEOUT   = 1023
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              trigger_read,
  input  logic              rom_q,
  input  logic              reconfig,
  input  logic              scandone,
  output logic [ADDR_W-1:0] address,
  output logic              read_ena,
  output logic              busy,
  output logic              scandata,
  output logic              scanclkena,
  output logic              configupdate,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCAN_LEN - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  state_t     state;
  logic [1:0] drain_cnt;
  logic       rc_pend;
  logic [1:0] valid;
  logic       rc_wait;
  logic       dn_wait;
  logic       rc_expired;
  logic       dn_expired;

  assign rc_wait = (state == S_WAIT_RECONF);
  assign dn_wait = (state == S_WAIT_DONE);

  pll_scan_timeout #(
    .LIMIT (RECONF_TIMEOUT)
  ) u_rc_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!rc_wait),
    .enable  (rc_wait),
    .expired (rc_expired)
  );

  pll_scan_timeout #(
    .LIMIT (DONE_TIMEOUT)
  ) u_dn_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!dn_wait),
    .enable  (dn_wait),
    .expired (dn_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      address      <= '0;
      read_ena     <= 1'b0;
      busy         <= 1'b0;
      configupdate <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      rc_pend      <= 1'b0;
      drain_cnt    <= '0;
    end else begin
      configupdate <= 1'b0;
      done         <= 1'b0;
      unique case (state)
        S_IDLE: begin
          address <= '0;
          rc_pend <= 1'b0;
          if (trigger_read) begin
            state    <= S_READ;
            busy     <= 1'b1;
            read_ena <= 1'b1;
            error    <= 1'b0;
          end
        end
        S_READ: begin
          if (reconfig) rc_pend <= 1'b1;
          if (address == LAST_ADDR) begin
            read_ena  <= 1'b0;
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else begin
            address <= address + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (reconfig) rc_pend <= 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_WAIT_RECONF;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        S_WAIT_RECONF: begin
          if (reconfig || rc_pend) begin
            rc_pend      <= 1'b0;
            configupdate <= 1'b1;
            state        <= S_UPDATE;
          end else if (rc_expired) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            address <= '0;
            state   <= S_IDLE;
          end
        end
        S_UPDATE: begin
          state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // success wins over a same-edge expiry
          if (scandone) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            address <= '0;
            state   <= S_IDLE;
          end else if (dn_expired) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            address <= '0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid      <= '0;
      scandata   <= 1'b0;
      scanclkena <= 1'b0;
    end else begin
      valid      <= {valid[0], read_ena};
      scanclkena <= valid[1];
      scandata   <= valid[1] & rom_q;
    end
  end

endmodule
